// File: rtl/multicycle_cu.sv
// Multi-cycle RV32I control unit: sequences each instruction through a shared
// ALU and unified memory, with optional memory ready handshake and a sticky trap.
module multicycle_cu #(
  parameter logic MEM_HANDSHAKE = 1'b1,
  parameter logic FULL_BRANCH   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       Illegal,
  output logic [3:0] state_o
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_LUI      = 4'd11;
  localparam logic [3:0] S_JALR     = 4'd12;
  localparam logic [3:0] S_TRAP     = 4'd15;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  logic [3:0] state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [3:0] dec_state;
  logic       ready;
  logic       alu_fmt_ok;
  logic       branch_ok;
  logic       taken;

  function automatic logic [2:0] funct_alu(input logic [2:0] f3, input logic sub_sel);
    case (f3)
      3'b000:  funct_alu = sub_sel ? ALU_SUB : ALU_ADD;
      3'b001:  funct_alu = ALU_SLL;
      3'b010:  funct_alu = ALU_SLT;
      3'b100:  funct_alu = ALU_XOR;
      3'b101:  funct_alu = ALU_SRL;
      3'b110:  funct_alu = ALU_OR;
      3'b111:  funct_alu = ALU_AND;
      default: funct_alu = ALU_ADD;
    endcase
  endfunction

  assign ready      = MEM_HANDSHAKE ? mem_ready : 1'b1;
  // slti-u hole (011) and arithmetic shifts are not supported by this ALU
  assign alu_fmt_ok = (funct3 != 3'b011) && !(funct7_5 && (funct3 == 3'b101));
  assign branch_ok  = FULL_BRANCH ? (funct3[2:1] != 2'b01) : (funct3 == 3'b000);

  always_comb begin
    dec_state = S_TRAP;
    case (op)
      OP_LOAD, OP_STORE: if (funct3 == 3'b010) dec_state = S_MEMADR;
      OP_R:              if (alu_fmt_ok) dec_state = S_EXECR;
      OP_I:              if (alu_fmt_ok) dec_state = S_EXECI;
      OP_BR:             if (branch_ok) dec_state = S_BRANCH;
      OP_JAL:            dec_state = S_JAL;
      OP_JALR:           dec_state = S_JALR;
      OP_LUI:            dec_state = S_LUI;
      default:           dec_state = S_TRAP;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (ready) state_d = S_DECODE;
      S_DECODE:   state_d = dec_state;
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BRANCH:   state_d = S_FETCH;
      S_LUI:      state_d = S_ALUWB;
      S_JALR:     state_d = S_JAL;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    case (op)
      OP_STORE: ImmSrc = 3'b001;
      OP_BR:    ImmSrc = 3'b010;
      OP_JAL:   ImmSrc = 3'b011;
      OP_LUI:   ImmSrc = 3'b100;
      default:  ImmSrc = 3'b000;
    endcase
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = ready;
        PCWrite   = ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = funct_alu(funct3, funct7_5);
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = funct_alu(funct3, 1'b0);
      end
      S_ALUWB:    RegWrite = 1'b1;
      // JAL links OldPC+4 into ALUOut while the target already in ALUOut loads the PC
      S_JAL: begin
        PCWrite = 1'b1;
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        PCWrite    = taken;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
      end
      S_JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      default: ;
    endcase
  end

  assign Illegal = illegal_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Scoreboard bench for multicycle_cu: the stimulus pushes per-cycle expectations
// from an instruction-level model; a negedge monitor pops and compares.
module tb_multicycle_cu;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rs, a, b;
    logic [2:0] imm, alu;
    logic       ill;
  } obs_t;

  typedef struct {
    int   d;
    obs_t o;
  } rec_t;

  typedef enum int {K_LOAD, K_STORE, K_R, K_I, K_BR, K_JAL, K_JALR, K_LUI, K_BAD} kind_t;

  logic       clk = 1'b0;
  logic       rst_s [2];
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5, zero, lt, ltu, mem_ready;

  logic       pcw [2], adr [2], mw [2], irw [2], rw [2], ill [2];
  logic [1:0] rs [2], sa [2], sb [2];
  logic [2:0] imm [2], alu [2];
  logic [3:0] st [2];

  rec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  rec_t mon_e;
  obs_t mon_a;

  always #5 clk = ~clk;

  multicycle_cu u_dut0 (
    .clk(clk), .rst(rst_s[0]), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .PCWrite(pcw[0]), .AdrSrc(adr[0]), .MemWrite(mw[0]), .IRWrite(irw[0]),
    .RegWrite(rw[0]), .ResultSrc(rs[0]), .ALUSrcA(sa[0]), .ALUSrcB(sb[0]),
    .ImmSrc(imm[0]), .ALUControl(alu[0]), .Illegal(ill[0]), .state_o(st[0])
  );

  multicycle_cu #(.MEM_HANDSHAKE(1'b0), .FULL_BRANCH(1'b0)) u_dut1 (
    .clk(clk), .rst(rst_s[1]), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .PCWrite(pcw[1]), .AdrSrc(adr[1]), .MemWrite(mw[1]), .IRWrite(irw[1]),
    .RegWrite(rw[1]), .ResultSrc(rs[1]), .ALUSrcA(sa[1]), .ALUSrcB(sb[1]),
    .ImmSrc(imm[1]), .ALUControl(alu[1]), .Illegal(ill[1]), .state_o(st[1])
  );

  // Instruction class from the encoding rules, including every trap case
  function automatic kind_t classify(input logic [6:0] o, input logic [2:0] f,
                                     input logic f7, input bit fb);
    bit alu_ok;
    alu_ok = (f != 3'd3) && !(f7 && f == 3'd5);
    case (o)
      7'b0000011: return (f == 3'd2) ? K_LOAD : K_BAD;
      7'b0100011: return (f == 3'd2) ? K_STORE : K_BAD;
      7'b0110011: return alu_ok ? K_R : K_BAD;
      7'b0010011: return alu_ok ? K_I : K_BAD;
      7'b1100011: begin
        if (fb) return (f != 3'd2 && f != 3'd3) ? K_BR : K_BAD;
        return (f == 3'd0) ? K_BR : K_BAD;
      end
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b0110111: return K_LUI;
      default:    return K_BAD;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0100011: return 3'd1;
      7'b1100011: return 3'd2;
      7'b1101111: return 3'd3;
      7'b0110111: return 3'd4;
      default:    return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [2:0] f, input bit is_r, input logic f7);
    case (f)
      3'd0:    return (is_r && f7) ? 3'd1 : 3'd0;
      3'd1:    return 3'd6;
      3'd2:    return 3'd5;
      3'd4:    return 3'd4;
      3'd5:    return 3'd7;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] f, input logic z, input logic l,
                                    input logic lu);
    case (f)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return l;
      3'd5:    return !l;
      3'd6:    return lu;
      3'd7:    return !lu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic obs_t model_out(input int s, input logic [6:0] o, input logic [2:0] f,
                                     input logic f7, input logic z, input logic l,
                                     input logic lu, input logic rdy);
    obs_t r;
    r     = '0;
    r.st  = s[3:0];
    r.imm = imm_of(o);
    case (s)
      0:  begin r.b = 2'd2; r.rs = 2'd2; r.irw = rdy; r.pcw = rdy; end
      1:  begin r.a = 2'd1; r.b = 2'd1; end
      2:  begin r.a = 2'd2; r.b = 2'd1; end
      3:  r.adr = 1'b1;
      4:  begin r.rs = 2'd1; r.rw = 1'b1; end
      5:  begin r.adr = 1'b1; r.mw = 1'b1; end
      6:  begin r.a = 2'd2; r.alu = alu_of(f, 1'b1, f7); end
      7:  begin r.a = 2'd2; r.b = 2'd1; r.alu = alu_of(f, 1'b0, f7); end
      8:  r.rw = 1'b1;
      9:  begin r.pcw = 1'b1; r.a = 2'd1; r.b = 2'd2; end
      10: begin r.a = 2'd2; r.alu = 3'd1; r.pcw = br_taken(f, z, l, lu); end
      11: begin r.a = 2'd3; r.b = 2'd1; end
      12: begin r.a = 2'd2; r.b = 2'd1; end
      15: r.ill = 1'b1;
      default: ;
    endcase
    return r;
  endfunction

  task automatic push_exp(input int d, input int s, input logic rdy);
    rec_t e;
    e.d = d;
    e.o = model_out(s, op, funct3, funct7_5, zero, lt, ltu, rdy);
    exp_q.push_back(e);
  endtask

  // Two cycles with reset held: FETCH outputs, Illegal cleared
  task automatic do_reset(input int d);
    rst_s[d]  = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push_exp(d, 0, (d == 0) ? 1'b0 : 1'b1);
      @(posedge clk); #1;
    end
    rst_s[d] = 1'b0;
  endtask

  task automatic run_instr(input int d, input logic [6:0] o, input logic [2:0] f,
                           input logic f7, input int wf_in, input int wm_in,
                           input int trap_n, input int abort_at, input int zf);
    int    sts[$];
    bit    rq[$];
    bit    hs;
    int    wf, wm;
    kind_t k;
    hs = (d == 0);
    wf = hs ? wf_in : 0;
    wm = hs ? wm_in : 0;
    k  = classify(o, f, f7, hs);
    for (int i = 0; i < wf; i++) begin sts.push_back(0); rq.push_back(1'b0); end
    sts.push_back(0); rq.push_back(1'b1);
    sts.push_back(1); rq.push_back(1'($urandom % 2));
    case (k)
      K_LOAD: begin
        sts.push_back(2); rq.push_back(1'($urandom % 2));
        for (int i = 0; i < wm; i++) begin sts.push_back(3); rq.push_back(1'b0); end
        sts.push_back(3); rq.push_back(1'b1);
        sts.push_back(4); rq.push_back(1'($urandom % 2));
      end
      K_STORE: begin
        sts.push_back(2); rq.push_back(1'($urandom % 2));
        for (int i = 0; i < wm; i++) begin sts.push_back(5); rq.push_back(1'b0); end
        sts.push_back(5); rq.push_back(1'b1);
      end
      K_R:    begin sts.push_back(6); sts.push_back(8); end
      K_I:    begin sts.push_back(7); sts.push_back(8); end
      K_BR:   sts.push_back(10);
      K_JAL:  begin sts.push_back(9); sts.push_back(8); end
      K_JALR: begin sts.push_back(12); sts.push_back(9); sts.push_back(8); end
      K_LUI:  begin sts.push_back(11); sts.push_back(8); end
      default: for (int i = 0; i < trap_n; i++) sts.push_back(15);
    endcase
    while (rq.size() < sts.size()) rq.push_back(1'($urandom % 2));
    if (!hs) for (int i = 0; i < rq.size(); i++) rq[i] = 1'($urandom % 2);
    op = o; funct3 = f; funct7_5 = f7;
    for (int i = 0; i < sts.size(); i++) begin
      if (i == abort_at) break;
      mem_ready = rq[i];
      zero = (zf < 0) ? 1'($urandom % 2) : zf[0];
      lt   = 1'($urandom % 2);
      ltu  = 1'($urandom % 2);
      push_exp(d, sts[i], hs ? mem_ready : 1'b1);
      @(posedge clk); #1;
    end
    if (k == K_BAD || abort_at >= 0) do_reset(d);
  endtask

  task automatic random_run(input int d, input int n);
    logic [6:0] tab [9];
    logic [6:0] o;
    logic [2:0] f;
    tab = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b1111111};
    for (int i = 0; i < n; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      o = (sel == 9) ? 7'($urandom) : tab[sel];
      f = 3'($urandom_range(0, 7));
      if ((o == 7'b0000011 || o == 7'b0100011) && ($urandom % 4 != 0)) f = 3'd2;
      run_instr(d, o, f, 1'($urandom % 2), $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(2, 4), -1, -1);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = '{st[mon_e.d], pcw[mon_e.d], adr[mon_e.d], mw[mon_e.d], irw[mon_e.d],
                rw[mon_e.d], rs[mon_e.d], sa[mon_e.d], sb[mon_e.d], imm[mon_e.d],
                alu[mon_e.d], ill[mon_e.d]};
      total++;
      if (mon_a !== mon_e.o) begin
        bad++;
        $display("FAIL cycle dut%0d exp_state=%0d got=%h want=%h (st,pcw,adr,mw,irw,rw,rs,a,b,imm,alu,ill)",
                 mon_e.d, mon_e.o.st, mon_a, mon_e.o);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_s[0] = 1'b1; rst_s[1] = 1'b1;
    op = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    do_reset(0);
    // Directed: add, lw with waits, sw with wait, bne both ways, jalr, trap, aborted load
    run_instr(0, 7'b0110011, 3'd0, 1'b0, 0, 0, 0, -1, -1);
    run_instr(0, 7'b0110011, 3'd0, 1'b1, 0, 0, 0, -1, -1);
    run_instr(0, 7'b0000011, 3'd2, 1'b0, 0, 2, 0, -1, -1);
    run_instr(0, 7'b0100011, 3'd2, 1'b0, 0, 1, 0, -1, -1);
    run_instr(0, 7'b1100011, 3'd1, 1'b0, 0, 0, 0, -1, 0);
    run_instr(0, 7'b1100011, 3'd1, 1'b0, 0, 0, 0, -1, 1);
    run_instr(0, 7'b1100111, 3'd0, 1'b0, 1, 0, 0, -1, -1);
    run_instr(0, 7'b1111111, 3'd0, 1'b0, 0, 0, 10, -1, -1);
    run_instr(0, 7'b0000011, 3'd2, 1'b0, 0, 3, 0, 4, -1);
    run_instr(0, 7'b0010011, 3'd5, 1'b1, 0, 0, 3, -1, -1);
    random_run(0, 250);
    rst_s[0] = 1'b1;
    do_reset(1);
    run_instr(1, 7'b1100011, 3'd1, 1'b0, 0, 0, 3, -1, 0);
    run_instr(1, 7'b1100011, 3'd0, 1'b0, 0, 0, 0, -1, 1);
    run_instr(1, 7'b0000011, 3'd2, 1'b0, 2, 2, 0, -1, -1);
    random_run(1, 80);
    @(posedge clk); #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
